regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

- Shares the single write port of the 8×8-bit register file between two requesters:
  - the pipeline writeback stage, which has priority and never waits unless told to;
  - a loader/debug port, which preloads registers over a valid/ready handshake.
- Sits between WB and the register file's write port, and adds two things:
  - a small loader FIFO;
  - a starvation guard that briefly stalls writeback.
- Exports a busy mask so the hazard logic can stall reads of registers with a queued loader write.

## Interface
Parameters:
- DEPTH, 2, loader FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles a non-empty FIFO may be denied before writeback is stalled (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- wb_valid  in  1  writeback write request this cycle
- wb_dest  in  3  writeback destination register
- wb_data  in  8  writeback data
- wb_stall  out  1  combinational; pipeline must hold wb_* unchanged this cycle
- ld_valid  in  1  loader request
- ld_ready  out  1  loader FIFO can accept
- ld_dest  in  3  loader destination register
- ld_data  in  8  loader data
- write_reg  out  1  registered write enable to register file
- rDest  out  3  registered write address
- writeData  out  8  registered write data
- busy_mask  out  8  bit i = 1 while any FIFO entry targets register i

## Operation
- Loader handshake:
  - An entry is pushed at the rising edge where ld_valid && ld_ready.
  - ld_ready = !full && !reset.
  - There is no push when full, even if a pop occurs in the same cycle.
- Grant decision each edge, evaluated in order:
  1. If the FIFO is non-empty and wb_stall = 1: pop the head and write it. wb_* is ignored.
  2. Else if wb_valid = 1: write wb_dest/wb_data.
  3. Else if the FIFO is non-empty: pop the head and write it.
  4. Else: write_reg = 0. rDest and writeData hold their last values.
- Starvation counter (starve_cnt, 0..STARVE_LIMIT):
  - Cleared when the FIFO is empty or the head is granted.
  - Otherwise increments, saturating at STARVE_LIMIT.
  - wb_stall = (starve_cnt == STARVE_LIMIT) && FIFO non-empty.
- busy_mask is the OR of the one-hot decodes of all valid entries, computed from the current FIFO state. It is not updated until the edge that pushes or pops.
- Same-destination collisions are not coalesced. Writes reach the register file in grant order, and the later grant wins.
- Destination 0 is treated like any other register. Any zero-register semantics belong to the register file.

## Timing
- Reset (sampled at the edge):
  - write_reg=0, rDest=0, writeData=0;
  - FIFO empty, busy_mask=0, starve_cnt=0, wb_stall=0, ld_ready=0 while reset is high.
- Writeback latency: wb_valid sampled at edge N gives write_reg=1 from N until N+1, so the register file commits at N+1.
- Loader latency:
  - Accepted at edge N, the entry can be granted at edge N+1 at the earliest.
  - The register file commits at N+2.
- Worst-case loader wait under continuous wb_valid: STARVE_LIMIT cycles denied, then granted on the next edge. At most one wb_stall cycle per popped entry.
- Simultaneous push and pop on a non-full FIFO: both take effect, and the count is unchanged.
- Reset asserted mid-operation:
  - All queued loader entries are discarded.
  - No write is issued on the reset edge.
  - An in-flight wb request is dropped, and the pipeline must be reset too.

## Structure
- Shared package `mips_pkg`:
  - REG_ADDR_W=3, DATA_W=8, NUM_REGS=8;
  - a write-request struct/typedef {dest, data}.
- One natural sub-module: `sync_fifo` (parameterised depth/width, full/empty/count, synchronous reset). It holds the loader queue.
- Arbitration, the starvation counter and busy-mask decode stay in the top module.

## Test plan
- Reset: hold reset for 2 cycles with ld_valid=1 → no pushes; all outputs 0; ld_ready=0 then 1 on the first cycle after release.
- WB only: wb_valid=1, dest=3, data=0x5A at edge N → write_reg=1, rDest=3, writeData=0x5A after N; write_reg=0 the next cycle if wb_valid drops.
- Loader only:
  - Push dest=5, data=0x11 then dest=6, data=0x22 → full.
  - ld_ready=0 and busy_mask=0x60 after the second push.
  - Writes issued in order 5 then 6; busy_mask returns to 0.
- Priority:
  - FIFO holds dest=2, data=0x33 while wb_valid=1, dest=2, data=0x44.
  - WB writes 0x44 first; the loader writes 0x33 one cycle later, so the final value is 0x33.
- Starvation:
  - Continuous wb_valid with one queued loader entry.
  - WB wins 4 consecutive edges; then wb_stall=1 for exactly one cycle; the loader entry is written; WB resumes with its held request.
- Mid-operation reset with 2 entries queued → FIFO empty, busy_mask=0, and no loader write ever appears.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the register-file write path.
// Holds the register/data widths and the write-request record.
package mips_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 8;
  localparam int NUM_REGS   = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } writeReq_t;

  // One-hot decode of a request's destination, used to build the busy mask.
  function automatic logic [NUM_REGS-1:0] destOneHot(input writeReq_t req);
    return NUM_REGS'(1) << req.dest;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with full/empty/count and a head-first view of every slot.
// Slot i of orderedData is meaningful only while i < count.
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              wrData,
  output logic                          full,
  output logic                          empty,
  output logic [PTR_W:0]                count,
  output logic [DEPTH-1:0][WIDTH-1:0]   orderedData
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wrPtr;
  logic [PTR_W-1:0]            rdPtr;
  logic                        doPush;
  logic                        doPop;

  assign full   = (count == (PTR_W+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      unique case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: a slot is only observed once it has been written.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  always_comb begin
    orderedData = '0;
    for (int i = 0; i < DEPTH; i++)
      orderedData[i] = mem[rdPtr + PTR_W'(i)];
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback (priority) and a
// queued loader port, with a starvation guard that briefly stalls writeback.
module regfile_write_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  wb_stall,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_dest,
  input  logic [DATA_W-1:0]     ld_data,
  output logic                  write_reg,
  output logic [REG_ADDR_W-1:0] rDest,
  output logic [DATA_W-1:0]     writeData,
  output logic [NUM_REGS-1:0]   busy_mask
);

  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int FIFO_W = $bits(writeReq_t);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                         fifoFull;
  logic                         fifoEmpty;
  logic [PTR_W:0]               fifoCount;
  logic [DEPTH-1:0][FIFO_W-1:0] queued;
  logic                         doPush;
  logic                         grantHead;
  logic                         grantWb;
  logic [CNT_W-1:0]             starveCnt;
  writeReq_t                    head;
  writeReq_t                    loaderReq;

  assign loaderReq = '{dest: ld_dest, data: ld_data};
  assign head      = queued[0];
  assign ld_ready  = !fifoFull && !reset;
  assign doPush    = ld_valid && ld_ready;

  // A saturated counter forces the head through, ignoring the stalled wb request.
  assign wb_stall  = !reset && !fifoEmpty && (starveCnt == CNT_W'(STARVE_LIMIT));
  assign grantHead = !fifoEmpty && (wb_stall || !wb_valid);
  assign grantWb   = !grantHead && wb_valid;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) loaderFifo (
    .clk         (clk),
    .reset       (reset),
    .push        (doPush),
    .pop         (grantHead),
    .wrData      (loaderReq),
    .full        (fifoFull),
    .empty       (fifoEmpty),
    .count       (fifoCount),
    .orderedData (queued)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      write_reg <= 1'b0;
      rDest     <= '0;
      writeData <= '0;
    end else begin
      write_reg <= grantHead || grantWb;
      if (grantHead) begin
        rDest     <= head.dest;
        writeData <= head.data;
      end else if (grantWb) begin
        rDest     <= wb_dest;
        writeData <= wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || fifoEmpty || grantHead)
      starveCnt <= '0;
    else if (starveCnt != CNT_W'(STARVE_LIMIT))
      starveCnt <= starveCnt + 1'b1;
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (i < int'(fifoCount)) busy_mask = busy_mask | destOneHot(queued[i]);
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a
// queue-based reference model of the arbitration rules.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       wb_valid;
  logic [2:0] wb_dest;
  logic [7:0] wb_data;
  logic       wb_stall;
  logic       ld_valid;
  logic       ld_ready;
  logic [2:0] ld_dest;
  logic [7:0] ld_data;
  logic       write_reg;
  logic [2:0] rDest;
  logic [7:0] writeData;
  logic [7:0] busy_mask;

  typedef struct {
    logic [2:0] dest;
    logic [7:0] data;
  } req_t;

  req_t       fifoModel[$];
  int         denied = 0;
  logic [2:0] lastDest = '0;
  logic [7:0] lastData = '0;
  int         vectors = 0;
  int         miscompares = 0;
  int         stallSeen = 0;
  int         loaderWrites = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_dest   (wb_dest),
    .wb_data   (wb_data),
    .wb_stall  (wb_stall),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_dest   (ld_dest),
    .ld_data   (ld_data),
    .write_reg (write_reg),
    .rDest     (rDest),
    .writeData (writeData),
    .busy_mask (busy_mask)
  );

  function automatic logic [7:0] modelMask();
    logic [7:0] m = '0;
    foreach (fifoModel[i]) m |= 8'(1) << fifoModel[i].dest;
    return m;
  endfunction

  function automatic logic modelStallNext();
    return (fifoModel.size() > 0) && (denied >= LIMIT);
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, advance the model, check registered outputs.
  task automatic applyStimulus(input logic rst, input logic wv, input logic [2:0] wd, input logic [7:0] wdat,
                               input logic lv, input logic [2:0] ldd, input logic [7:0] ldat);
    logic expStall, expWrite, popHead, pushOk;
    reset = rst; wb_valid = wv; wb_dest = wd; wb_data = wdat;
    ld_valid = lv; ld_dest = ldd; ld_data = ldat;
    #1;
    expStall = !rst && modelStallNext();
    checkOutput("wb_stall", 8'(wb_stall), 8'(expStall));
    checkOutput("ld_ready", 8'(ld_ready), 8'(!rst && (fifoModel.size() < DEPTH)));
    if (wb_stall) stallSeen++;
    popHead = 1'b0; expWrite = 1'b0;
    if (rst) begin
      fifoModel.delete();
      denied = 0; lastDest = '0; lastData = '0;
    end else begin
      if (fifoModel.size() > 0 && (expStall || !wv)) begin
        popHead = 1'b1; expWrite = 1'b1;
        lastDest = fifoModel[0].dest; lastData = fifoModel[0].data;
        loaderWrites++;
      end else if (wv) begin
        expWrite = 1'b1; lastDest = wd; lastData = wdat;
      end
      if (fifoModel.size() == 0 || popHead) denied = 0;
      else if (denied < LIMIT) denied++;
      pushOk = lv && (fifoModel.size() < DEPTH);
      if (popHead) void'(fifoModel.pop_front());
      if (pushOk) fifoModel.push_back('{ldd, ldat});
    end
    @(posedge clk);
    #1;
    checkOutput("write_reg", 8'(write_reg), 8'(expWrite));
    checkOutput("rDest", 8'(rDest), 8'(lastDest));
    checkOutput("writeData", writeData, lastData);
    checkOutput("busy_mask", busy_mask, modelMask());
  endtask

  initial begin
    logic       wv;
    logic [2:0] wd;
    logic [7:0] wdat;

    // Reset held with a loader request pending, then release.
    applyStimulus(1, 0, 0, 8'h00, 1, 3'd4, 8'hEE);
    applyStimulus(1, 0, 0, 8'h00, 1, 3'd4, 8'hEE);
    checkOutput("reset_busy", busy_mask, 8'h00);
    applyStimulus(0, 0, 0, 8'h00, 0, 0, 8'h00);

    // Writeback only.
    applyStimulus(0, 1, 3'd3, 8'h5A, 0, 0, 8'h00);
    checkOutput("wb_dest3", 8'(rDest), 8'h03);
    applyStimulus(0, 0, 0, 8'h00, 0, 0, 8'h00);

    // Loader fills while writeback is busy, then drains in order.
    applyStimulus(0, 1, 3'd0, 8'h01, 1, 3'd5, 8'h11);
    applyStimulus(0, 1, 3'd0, 8'h02, 1, 3'd6, 8'h22);
    checkOutput("full_busy", busy_mask, 8'h60);
    checkOutput("full_ready", 8'(ld_ready), 8'h00);
    applyStimulus(0, 0, 0, 8'h00, 0, 0, 8'h00);
    checkOutput("drain_first", 8'(rDest), 8'h05);
    applyStimulus(0, 0, 0, 8'h00, 0, 0, 8'h00);
    checkOutput("drain_second", 8'(rDest), 8'h06);
    checkOutput("drain_busy", busy_mask, 8'h00);

    // Priority: same destination, writeback first, loader value lands last.
    applyStimulus(0, 1, 3'd7, 8'h70, 1, 3'd2, 8'h33);
    applyStimulus(0, 1, 3'd2, 8'h44, 0, 0, 8'h00);
    checkOutput("prio_wb", writeData, 8'h44);
    applyStimulus(0, 0, 0, 8'h00, 0, 0, 8'h00);
    checkOutput("prio_loader", writeData, 8'h33);

    // Starvation under continuous writeback; wb request held while stalled.
    stallSeen = 0;
    wd = 3'd1; wdat = 8'h80;
    applyStimulus(0, 1, wd, wdat, 1, 3'd4, 8'h99);
    for (int i = 0; i < 8; i++) begin
      if (!modelStallNext()) wdat = wdat + 8'h01;
      applyStimulus(0, 1, wd, wdat, 0, 0, 8'h00);
    end
    checkOutput("starve_stalls", 8'(stallSeen), 8'h01);

    // Reset with two entries queued: they must never be written.
    applyStimulus(0, 1, 3'd0, 8'hA0, 1, 3'd3, 8'hC3);
    applyStimulus(0, 1, 3'd0, 8'hA1, 1, 3'd4, 8'hC4);
    loaderWrites = 0;
    applyStimulus(1, 1, 3'd0, 8'hA2, 0, 0, 8'h00);
    checkOutput("midreset_busy", busy_mask, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 8'h00, 0, 0, 8'h00);
    checkOutput("midreset_nowrite", 8'(loaderWrites), 8'h00);

    // Random traffic; the pipeline holds its request while stalled.
    wv = 1'b0; wd = '0; wdat = '0;
    for (int i = 0; i < 400; i++) begin
      if (!modelStallNext()) begin
        wv   = ($urandom_range(0, 99) < 60);
        wd   = 3'($urandom_range(0, 7));
        wdat = 8'($urandom_range(0, 255));
      end
      applyStimulus(($urandom_range(0, 99) < 2), wv, wd, wdat,
                    ($urandom_range(0, 99) < 50), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
